// File: rtl/cdc1_drv.sv
// cdc1_drv: phase controller sequencing the cdc1 charge/discharge gates with
// guaranteed dead time, abort handling and synchronised VO sense sampling.
module cdc1_drv #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] t_chg,
  input  logic [CNT_W-1:0] t_dead,
  input  logic [CNT_W-1:0] t_dis,
  input  logic             vo_sense,
  output logic             i1,
  output logic             i2,
  output logic             busy,
  output logic             done,
  output logic             chg_hi,
  output logic             dis_lo,
  output logic             aborted
);
  typedef enum logic [2:0] {IDLE, CHG, DEAD1, DIS, DEAD2, FIN} state_t;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t st, nst;
  logic [CNT_W-1:0] cnt, ncnt, tdead_q, tdis_q, tchg_m, tdead_m, tdis_m;
  logic [SYNC_STAGES-1:0] sy;
  logic vs, last, ab, nab, smp_chg, smp_dis, chg_s, dis_s;
  assign tchg_m  = (t_chg  == '0) ? ONE : t_chg;
  assign tdead_m = (t_dead == '0) ? ONE : t_dead;
  assign tdis_m  = (t_dis  == '0) ? ONE : t_dis;
  assign vs      = sy[SYNC_STAGES-1];
  assign last    = cnt == ONE;
  // Abort outranks counter expiry; in a dead phase it only redirects to DEAD2.
  always_comb begin
    nst     = st;
    ncnt    = cnt;
    nab     = ab;
    smp_chg = 1'b0;
    smp_dis = 1'b0;
    case (st)
      IDLE: if (start) begin
        nst  = CHG;
        ncnt = tchg_m;
        nab  = 1'b0;
      end
      CHG: begin
        nst     = (abort || last) ? (abort ? DEAD2 : DEAD1) : CHG;
        ncnt    = (abort || last) ? tdead_q : cnt - ONE;
        nab     = ab | abort;
        smp_chg = last & ~abort;
      end
      DIS: begin
        nst     = (abort || last) ? DEAD2 : DIS;
        ncnt    = (abort || last) ? tdead_q : cnt - ONE;
        nab     = ab | abort;
        smp_dis = last & ~abort;
      end
      DEAD1, DEAD2: begin
        nab  = ab | abort;
        nst  = last ? ((st == DEAD2 || abort) ? FIN : DIS) : (abort ? DEAD2 : st);
        ncnt = last ? ((st == DEAD2 || abort) ? '0 : tdis_q) : cnt - ONE;
      end
      FIN: nst = IDLE;
      default: begin
        nst  = IDLE;
        ncnt = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      cnt     <= '0;
      ab      <= 1'b0;
      sy      <= '0;
      tdead_q <= ONE;
      tdis_q  <= ONE;
      chg_s   <= 1'b0;
      dis_s   <= 1'b0;
      i1      <= 1'b1;
      i2      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      chg_hi  <= 1'b0;
      dis_lo  <= 1'b0;
      aborted <= 1'b0;
    end else begin
      st   <= nst;
      cnt  <= ncnt;
      ab   <= nab;
      sy   <= {sy[SYNC_STAGES-2:0], vo_sense};
      if (st == IDLE && start) begin
        tdead_q <= tdead_m;
        tdis_q  <= tdis_m;
      end
      if (smp_chg) chg_s <= vs;
      if (smp_dis) dis_s <= ~vs;
      // Gate drives are registered from the next state so they never glitch.
      i1   <= nst != CHG;
      i2   <= nst == DIS;
      busy <= nst != IDLE;
      done <= nst == FIN;
      if (nst == FIN) begin
        chg_hi  <= chg_s;
        dis_lo  <= dis_s;
        aborted <= nab;
      end
    end
  end
endmodule
